// File: rtl/spram_be_pipe_if.sv
// ---------------------------------------------------------------------------
// spram_be_pipe_if
// Bus bundle for the byte-enabled simple dual-port RAM (spram_be_pipe).
//   master : feeder/drain side. Drives the write port (wr_en, wr_addr, wr_be,
//            wr_data) and the read request (rd_en, rd_addr). Receives busy,
//            rd_data and rd_valid.
//   slave  : the RAM itself, with every direction reversed.
// Parameters:
//   AW  address width
//   DW  data width
//   BW  byte-lane width (NB = DW/BW lanes)
// ---------------------------------------------------------------------------
interface spram_be_pipe_if #(
   parameter int AW = 12,
   parameter int DW = 16,
   parameter int BW = 8
);
   localparam int NB = DW / BW;

   logic          busy;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [NB-1:0] wr_be;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;

   modport master (
      input  busy,
      input  rd_data,
      input  rd_valid,
      output wr_en,
      output wr_addr,
      output wr_be,
      output wr_data,
      output rd_en,
      output rd_addr
   );

   modport slave (
      output busy,
      output rd_data,
      output rd_valid,
      input  wr_en,
      input  wr_addr,
      input  wr_be,
      input  wr_data,
      input  rd_en,
      input  rd_addr
   );
endinterface

// File: rtl/spram_be_pipe.sv
// ---------------------------------------------------------------------------
// spram_be_pipe
// Simple dual-port synchronous RAM (one write port, one read port, one clock)
// used as the operand/result buffer next to the systolic array.
//
// Ports:
//   clk   rising-edge clock for all logic
//   rst   synchronous, active-high reset; wins over every other input
//   bus   spram_be_pipe_if.slave
//           busy      clear engine running, both ports ignored
//           wr_en     write request
//           wr_addr   write address
//           wr_be     per-lane write enables, bit i covers data[i*BW +: BW]
//           wr_data   write data
//           rd_en     read request
//           rd_addr   read address
//           rd_data   read data, holds its value while rd_valid is low
//           rd_valid  rd_data is the result of a read issued RD_LAT cycles ago
//
// Parameters:
//   AW              address width, depth = 2**AW
//   DW              data width, multiple of BW
//   BW              byte-lane width
//   RD_LAT          read latency, 1 or 2
//   RDW_MODE        same-address read-during-write: 0 old word, 1 byte-merged
//                   new word
//   CLEAR_ON_RESET  1 zeroes every word after reset (busy for 2**AW cycles)
//
// Clear FSM:
//   state   | meaning
//   S_IDLE  | normal operation, both ports live
//   S_CLEAR | zeroing mem[cnt] each cycle, cnt 0 .. 2**AW-1, busy high
// ---------------------------------------------------------------------------
module spram_be_pipe #(
   parameter int AW             = 12,
   parameter int DW             = 16,
   parameter int BW             = 8,
   parameter int RD_LAT         = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            rst,
   spram_be_pipe_if.slave  bus
);

   localparam int NB    = DW / BW;
   localparam int DEPTH = 2 ** AW;

   // ------------------------------------------------------------------------
   // Parameter legality, caught at elaboration
   // ------------------------------------------------------------------------
   if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("spram_be_pipe: RD_LAT must be 1 or 2");
   end

   if ((DW % BW) != 0) begin : g_bad_dw
      $error("spram_be_pipe: DW must be a multiple of BW");
   end

   if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw
      $error("spram_be_pipe: RDW_MODE must be 0 or 1");
   end

   if ((CLEAR_ON_RESET != 0) && (CLEAR_ON_RESET != 1)) begin : g_bad_clr
      $error("spram_be_pipe: CLEAR_ON_RESET must be 0 or 1");
   end

   // ------------------------------------------------------------------------
   // Clear FSM
   // ------------------------------------------------------------------------
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          busy_q;

   // busy_q is a registered copy of (state == S_CLEAR), kept separate so the
   // output does not depend on the state encoding.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         if (CLEAR_ON_RESET != 0) begin
            state  <= S_CLEAR;
            busy_q <= 1'b1;
         end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
         end
      end else begin
         case (state)
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == {AW{1'b1}}) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Qualified port requests: dropped while clearing or in reset
   // ------------------------------------------------------------------------
   logic clr_we;
   logic wr_fire;
   logic rd_fire;

   assign clr_we  = ~rst & (state == S_CLEAR);
   assign wr_fire = ~rst & ~busy_q & bus.wr_en;
   assign rd_fire = ~rst & ~busy_q & bus.rd_en;

   // ------------------------------------------------------------------------
   // Storage array
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) begin
               mem[bus.wr_addr][i*BW +: BW] <= bus.wr_data[i*BW +: BW];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read path, first stage
   // The array read sees the pre-write word because the write lands on the
   // same edge. In new-data mode, lanes being written to the same address
   // are bypassed from wr_data.
   // ------------------------------------------------------------------------
   logic [DW-1:0] rd_word;
   logic [DW-1:0] rd_merged;
   logic          rdw_hit;

   assign rdw_hit = (RDW_MODE != 0) && wr_fire && (bus.wr_addr == bus.rd_addr);

   always_comb begin
      rd_word   = mem[bus.rd_addr];
      rd_merged = rd_word;
      if (rdw_hit) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) begin
               rd_merged[i*BW +: BW] = bus.wr_data[i*BW +: BW];
            end
         end
      end
   end

   logic          v1;
   logic [DW-1:0] d1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_fire;
         if (rd_fire) begin
            d1 <= rd_merged;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Optional output stage for RD_LAT = 2; data only moves with valid so the
   // output holds between results.
   // ------------------------------------------------------------------------
   if (RD_LAT == 2) begin : g_lat2
      logic          v2;
      logic [DW-1:0] d2;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) begin
               d2 <= d1;
            end
         end
      end

      assign bus.rd_valid = v2;
      assign bus.rd_data  = d2;
   end else begin : g_lat1
      assign bus.rd_valid = v1;
      assign bus.rd_data  = d1;
   end

   assign bus.busy = busy_q;

endmodule

// File: tb/tb_spram_be_pipe.sv
// ---------------------------------------------------------------------------
// tb_spram_be_pipe
// Two instances share one stimulus stream:
//   dut_a : AW=4, RD_LAT=1, RDW_MODE=0 (old data)
//   dut_b : AW=4, RD_LAT=2, RDW_MODE=1 (byte-merged new data)
// A cycle-level reference model (word array plus a result schedule indexed
// by the cycle a result is due) is checked against both DUTs on every
// cycle; directed literal checks pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_spram_be_pipe;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int BW    = 8;
   localparam int NB    = DW / BW;
   localparam int DEPTH = 2 ** AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst     = 1'b0;
   logic          wr_en   = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [NB-1:0] wr_be   = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en   = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   spram_be_pipe_if #(.AW(AW), .DW(DW), .BW(BW)) bus_a ();
   spram_be_pipe_if #(.AW(AW), .DW(DW), .BW(BW)) bus_b ();

   assign bus_a.wr_en   = wr_en;
   assign bus_a.wr_addr = wr_addr;
   assign bus_a.wr_be   = wr_be;
   assign bus_a.wr_data = wr_data;
   assign bus_a.rd_en   = rd_en;
   assign bus_a.rd_addr = rd_addr;
   assign bus_b.wr_en   = wr_en;
   assign bus_b.wr_addr = wr_addr;
   assign bus_b.wr_be   = wr_be;
   assign bus_b.wr_data = wr_data;
   assign bus_b.rd_en   = rd_en;
   assign bus_b.rd_addr = rd_addr;

   spram_be_pipe #(
      .AW(AW), .DW(DW), .BW(BW), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   spram_be_pipe #(
      .AW(AW), .DW(DW), .BW(BW), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // ------------------------------------------------------------------------
   // Reference model. Edge number cyc; a read accepted at edge n is due on
   // the outputs right after edge n + LAT - 1.
   // ------------------------------------------------------------------------
   logic [DW-1:0] mmem [DEPTH];
   bit            sv0 [64];
   bit            sv1 [64];
   logic [DW-1:0] sd0 [64];
   logic [DW-1:0] sd1 [64];
   int            cyc       = 0;
   int            busy_left = 0;
   logic          eb  = 1'b0;
   logic          ev0 = 1'b0;
   logic          ev1 = 1'b0;
   logic [DW-1:0] ed0 = '0;
   logic [DW-1:0] ed1 = '0;

   always @(posedge clk) begin : model
      logic [DW-1:0] mask;
      logic [DW-1:0] old_w;
      cyc = cyc + 1;
      mask = {{BW{wr_be[1]}}, {BW{wr_be[0]}}};
      if (rst) begin
         busy_left = DEPTH;
         for (int k = 0; k < 64; k++) begin
            sv0[k] = 1'b0;
            sv1[k] = 1'b0;
         end
         ev0 = 1'b0;
         ev1 = 1'b0;
         ed0 = '0;
         ed1 = '0;
      end else begin
         if (busy_left > 0) begin
            mmem[DEPTH - busy_left] = '0;
            busy_left = busy_left - 1;
         end else begin
            if (rd_en) begin
               old_w = mmem[rd_addr];
               sv0[cyc % 64] = 1'b1;
               sd0[cyc % 64] = old_w;
               sv1[(cyc + 1) % 64] = 1'b1;
               if (wr_en && (wr_addr == rd_addr))
                  sd1[(cyc + 1) % 64] = (old_w & ~mask) | (wr_data & mask);
               else
                  sd1[(cyc + 1) % 64] = old_w;
            end
            if (wr_en)
               mmem[wr_addr] = (mmem[wr_addr] & ~mask) | (wr_data & mask);
         end
         ev0 = sv0[cyc % 64];
         if (ev0) ed0 = sd0[cyc % 64];
         sv0[cyc % 64] = 1'b0;
         ev1 = sv1[cyc % 64];
         if (ev1) ed1 = sd1[cyc % 64];
         sv1[cyc % 64] = 1'b0;
      end
      eb = (busy_left > 0);
   end

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] wa,
                        input logic [NB-1:0] be, input logic [DW-1:0] wd,
                        input logic r, input logic [AW-1:0] ra);
      wr_en   = w;
      wr_addr = wa;
      wr_be   = be;
      wr_data = wd;
      rd_en   = r;
      rd_addr = ra;
      tick();
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : stim
      int            cnt_a;
      int            cnt_b;
      logic          saw_valid;
      logic [DW-1:0] v;

      rst = 1'b1;
      tick();

      fork
         forever begin
            @(negedge clk);
            check("a_busy",  16'(bus_a.busy),     16'(eb));
            check("b_busy",  16'(bus_b.busy),     16'(eb));
            check("a_valid", 16'(bus_a.rd_valid), 16'(ev0));
            check("b_valid", 16'(bus_b.rd_valid), 16'(ev1));
            check("a_data",  bus_a.rd_data,       ed0);
            check("b_data",  bus_b.rd_data,       ed1);
         end
      join_none

      // Reset, requests held high during the clear, reset again mid-clear.
      rst     = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 4'd9;
      wr_be   = 2'b11;
      wr_data = 16'hFFFF;
      rd_en   = 1'b1;
      rd_addr = 4'd0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      cnt_a     = 0;
      cnt_b     = 0;
      saw_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus_a.busy) cnt_a++;
         if (bus_b.busy) cnt_b++;
         if (bus_a.rd_valid || bus_b.rd_valid) saw_valid = 1'b1;
         if (!bus_a.busy && !bus_b.busy) break;
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("busy_cycles_a", 16'(cnt_a), 16'd16);
      check("busy_cycles_b", 16'(cnt_b), 16'd16);
      check("valid_during_busy", 16'(saw_valid), 16'd0);

      // Every word reads back zero, including the one written during busy.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, '0, '0, '0, 1'b1, 4'(i));
         @(negedge clk);
         check("clr_a_data",  bus_a.rd_data, 16'h0000);
         check("clr_a_valid", 16'(bus_a.rd_valid), 16'd1);
      end
      idle();

      // Byte enables.
      drive(1'b1, 4'd5, 2'b11, 16'hABCD, 1'b0, '0);
      drive(1'b1, 4'd5, 2'b10, 16'h1200, 1'b0, '0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd5);
      @(negedge clk);
      check("be_a", bus_a.rd_data, 16'h12CD);
      idle();
      @(negedge clk);
      check("be_b", bus_b.rd_data, 16'h12CD);

      // Read-during-write, full word.
      drive(1'b1, 4'd3, 2'b11, 16'h1111, 1'b0, '0);
      drive(1'b1, 4'd3, 2'b11, 16'h2222, 1'b1, 4'd3);
      @(negedge clk);
      check("rdw_full_a", bus_a.rd_data, 16'h1111);
      idle();
      @(negedge clk);
      check("rdw_full_b", bus_b.rd_data, 16'h2222);

      // Read-during-write, low lane only, then read the next cycle.
      drive(1'b1, 4'd3, 2'b11, 16'h1111, 1'b0, '0);
      drive(1'b1, 4'd3, 2'b01, 16'h2222, 1'b1, 4'd3);
      @(negedge clk);
      check("rdw_lane_a", bus_a.rd_data, 16'h1111);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd3);
      @(negedge clk);
      check("rdw_lane_b", bus_b.rd_data, 16'h1122);
      check("wr_visible_a", bus_a.rd_data, 16'h1122);
      idle();
      @(negedge clk);
      check("wr_visible_b", bus_b.rd_data, 16'h1122);

      // Back-to-back reads 0..7.
      for (int i = 0; i < 8; i++) begin
         v = 16'hA0B0 + 16'(i) * 16'h0101;
         drive(1'b1, 4'(i), 2'b11, v, 1'b0, '0);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, '0, '0, 1'b1, 4'(i));
         @(negedge clk);
         v = 16'hA0B0 + 16'(i) * 16'h0101;
         check("tput_a_data", bus_a.rd_data, v);
         check("tput_b_valid", 16'(bus_b.rd_valid), (i > 0) ? 16'd1 : 16'd0);
         if (i > 0) begin
            v = 16'hA0B0 + 16'(i - 1) * 16'h0101;
            check("tput_b_data", bus_b.rd_data, v);
         end
      end
      idle();
      @(negedge clk);
      check("tput_b_last_valid", 16'(bus_b.rd_valid), 16'd1);
      check("tput_b_last_data", bus_b.rd_data, 16'hA7B7);
      idle();
      @(negedge clk);
      check("tput_b_end_valid", 16'(bus_b.rd_valid), 16'd0);
      check("tput_b_hold_data", bus_b.rd_data, 16'hA7B7);

      // Different addresses in the same cycle are independent.
      drive(1'b1, 4'd6, 2'b11, 16'hBEEF, 1'b1, 4'd5);
      @(negedge clk);
      check("indep_a", bus_a.rd_data, 16'hA5B5);
      idle();
      @(negedge clk);
      check("indep_b", bus_b.rd_data, 16'hA5B5);

      // Mixed traffic over the whole array, checked against the model.
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      repeat (3) idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spram_be_pipe.md
Name: spram_be_pipe

Overview:
- Parametrised successor to the team's single-port synchronous RAM.
- Simple dual-port: one write port and one read port on the same clock.
- Adds per-byte write enables, selectable read latency (1 or 2) with a valid strobe, defined read-during-write semantics, and a sequential clear engine that zeroes memory after reset.
- Used as the operand/result buffer beside the systolic array, where the feeder and drain sides run concurrently.

Parameters:
- AW, 12, address width; depth = 2**AW words.
- DW, 16, data width; must be a multiple of BW.
- BW, 8, byte-lane width; NB = DW/BW lanes.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no clear, contents undefined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- busy  out  1  clear engine running; both ports are ignored while high.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_be  in  NB  byte-lane enables; bit i covers data[i*BW +: BW].
- wr_data  in  DW  write data.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data carries the result of a read issued RD_LAT cycles earlier.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, read pipeline flushed, clear counter=0. busy=1 if CLEAR_ON_RESET=1, else 0. Reset wins over every other input.
- Clear FSM has two states.
  - CLEAR: entered on rst when CLEAR_ON_RESET=1. Writes all-zero to address cnt each cycle, cnt increments 0 .. 2**AW-1. busy=1.
  - On the cycle the last address is written, go to IDLE. busy falls on the next edge, so busy is high for exactly 2**AW cycles after rst deasserts.
  - IDLE: normal operation.
- rst asserted mid-clear restarts the clear at address 0.
- While busy=1: wr_en and rd_en are dropped, no read is queued, and rd_valid stays 0.
- Write: when wr_en=1 and busy=0, at the edge, each lane i with wr_be[i]=1 takes wr_data lane i. Lanes with be=0 keep their old contents. wr_be=0 is a no-op.
- Read: when rd_en=1 and busy=0 in cycle t, rd_valid=1 and rd_data=mem[rd_addr] are presented in cycle t+RD_LAT.
  - Back-to-back reads give one result per cycle (full throughput).
  - rd_data holds its last value while rd_valid=0.
- RD_LAT=2 adds one output register stage after the array read. Data and valid are delayed together.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: result is the pre-write word.
  - RDW_MODE=1: result lanes with wr_be=1 carry the new wr_data; other lanes carry old data.
- Different addresses are fully independent.
- A write in cycle t is visible to any read issued in t+1 or later, for either RDW_MODE.
- Address wraps naturally at 2**AW; there are no out-of-range addresses.
- Illegal parameters (RD_LAT not 1 or 2, DW not a multiple of BW) raise an elaboration-time error.

Test Plan:
- Clear, AW=4, CLEAR_ON_RESET=1: pulse rst for 1 cycle -> busy high exactly 16 cycles; then read all 16 addresses -> each returns 0x0000 with rd_valid exactly RD_LAT cycles after its rd_en.
- Byte enables: write 0xABCD to addr 5 with be=11, then 0x1200 with be=10 -> read of addr 5 returns 0x12CD.
- Read-during-write: addr 3 holds 0x1111. Same cycle, write 0x2222 (be=11) and read addr 3 -> RDW_MODE=0 returns 0x1111; RDW_MODE=1 returns 0x2222. With be=01, RDW_MODE=1 returns 0x1122.
- Latency/throughput, RD_LAT=2: reads of addrs 0..7 on consecutive cycles -> 8 consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in issue order.
- Reset mid-clear: assert rst at clear cycle 7 -> busy remains high, clear restarts at addr 0, busy totals 16 cycles after the last rst. A write attempted during busy is ignored (later read returns 0).
- Ignore during busy: rd_en held high throughout clear -> rd_valid stays 0 until busy=0.
